// File: rtl/full_adder_pkg.sv
// Shared width and word type for the registered integer adder.
package full_adder_pkg;
  localparam int ADDER_WIDTH = 32;
  typedef logic [ADDER_WIDTH-1:0] word_t;
endpackage

// File: rtl/full_adder_1b.sv
// One-bit full adder cell, the link of the ripple-carry chain.
module full_adder_1b (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);
endmodule

// File: rtl/full_adder_32b.sv
// Registered unsigned adder: WIDTH-bit ripple chain feeding one output register.
module full_adder_32b
  import full_adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder_1b u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (c[i]),
      .s   (s[i]),
      .cout(c[i+1])
    );
  end

  // No enable: every edge out of reset captures the current operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum   <= '0;
      carry <= 1'b0;
    end else begin
      sum   <= s;
      carry <= c[WIDTH];
    end
  end
endmodule

// File: tb/tb_full_adder_32b.sv
// Scoreboard bench: expected a+b queued at each capturing edge, monitor compares at negedge.
module tb_full_adder_32b;
  import full_adder_pkg::*;

  localparam int W = ADDER_WIDTH;

  logic  clk;
  logic  rst_n;
  word_t a, b;
  word_t sum;
  logic  carry;

  int checks = 0;
  int errors = 0;

  logic [W:0] exp_q[$];

  full_adder_32b #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a),
    .b    (b),
    .sum  (sum),
    .carry(carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain 33-bit arithmetic on the pair present at the capturing edge.
  always @(posedge clk) begin
    if (rst_n) exp_q.push_back({1'b0, a} + {1'b0, b});
  end

  always @(negedge clk) begin
    logic [W:0] exp;
    if (!rst_n) begin
      checks++;
      if ({carry, sum} !== '0) begin
        errors++;
        $display("FAIL reset_hold got carry=%0b sum=%08h want carry=0 sum=00000000", carry, sum);
      end
    end else if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      checks++;
      if ({carry, sum} !== exp) begin
        errors++;
        $display("FAIL add got carry=%0b sum=%08h want carry=%0b sum=%08h",
                 carry, sum, exp[W], exp[W-1:0]);
      end
    end
  end

  task automatic drive(input word_t x, input word_t y);
    @(negedge clk);
    #1;
    a = x;
    b = y;
  endtask

  task automatic midstream_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if ({carry, sum} !== '0) begin
      errors++;
      $display("FAIL async_reset got carry=%0b sum=%08h want carry=0 sum=00000000", carry, sum);
    end
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    a     = 32'hFFFF_FFFF;
    b     = 32'h0000_0001;
    #1;
    checks++;
    if ({carry, sum} !== '0) begin
      errors++;
      $display("FAIL reset_initial got carry=%0b sum=%08h want 0", carry, sum);
    end
    repeat (4) @(negedge clk);
    #1;
    rst_n = 1'b1;

    drive(32'h1234_5678, 32'h8765_4321);
    drive(32'hFFFF_FFFF, 32'h0000_0001);
    drive(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    drive(32'h8000_0000, 32'h8000_0000);
    drive(32'h0000_0000, 32'h0000_0000);
    drive(32'h7FFF_FFFF, 32'h0000_0001);

    for (int i = 0; i < 8; i++) drive($urandom, $urandom);
    midstream_reset();
    for (int i = 0; i < 8; i++) drive($urandom, $urandom);
    midstream_reset();

    for (int i = 0; i < 1000; i++) drive($urandom, $urandom);

    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() > 1) begin
      errors++;
      $display("FAIL drain got pending=%0d want <=1", exp_q.size());
    end
    checks++;
    if (checks < 1000) begin
      errors++;
      $display("FAIL check_count got %0d want >=1000", checks);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
